// File: rtl/fp_arith_arb.sv
// fp_arith_arb: round-robin arbiter that time-shares one combinational FP32 add/sub
// datapath (fp_arith) among NUM_REQ requesters. One operation in flight at a time:
// IDLE grants and latches operands, CALC captures the adder output, RESP holds it.

module fp_arith_arb #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REQ    = 4,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2,
  input  logic [NUM_REQ-1:0]            req_op_sel,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]               resp_id,
  output logic                          busy,
  output logic [15:0]                   op_cnt
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e                state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [DATA_WIDTH-1:0] opa_q, opb_q;
  logic                  op_q;
  logic [ID_W-1:0]       id_q;
  logic [15:0]           op_cnt_q;

  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       next_ptr;
  logic [DATA_WIDTH-1:0] win_d1, win_d2;
  logic                  win_op;
  logic [DATA_WIDTH-1:0] fp_out;

  assign op_cnt = op_cnt_q;

  // Rotating priority scan starting at ptr_q; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int              idx;
      logic [ID_W-1:0] idx_w;
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      idx_w = ID_W'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  // Operand mux for the winning requester and the post-grant pointer.
  always_comb begin
    win_d1 = '0;
    win_d2 = '0;
    win_op = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (win_id == ID_W'(k)) begin
        win_d1 = req_data_1[k*DATA_WIDTH +: DATA_WIDTH];
        win_d2 = req_data_2[k*DATA_WIDTH +: DATA_WIDTH];
        win_op = req_op_sel[k];
      end
    end
    next_ptr = (int'(win_id) == int'(NUM_REQ) - 1) ? '0 : win_id + 1'b1;
  end

  // Grant is combinational and only offered in IDLE outside reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle) && win_found) req_ready[win_id] = 1'b1;
  end

  // Sequencer: grant/latch, capture result, hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      op_cnt_q   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= 1'b0;
      id_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            opa_q   <= win_d1;
            opb_q   <= win_d2;
            op_q    <= win_op;
            id_q    <= win_id;
            ptr_q   <= next_ptr;
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          resp_data  <= fp_out;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            op_cnt_q   <= op_cnt_q + 16'd1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fp_arith u_fp_arith (
    .data_1 (opa_q),
    .data_2 (opb_q),
    .op_sel (op_q),
    .data_o (fp_out)
  );

endmodule

// fp_arith: combinational IEEE-754 binary32 add/subtract, round-to-nearest-even,
// subnormal inputs/outputs supported, any NaN yields the canonical quiet NaN.
module fp_arith (
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic        op_sel,
  output logic [31:0] data_o
);

  logic        sa, sb, s_big;
  logic [7:0]  ea, eb, e_big_raw, e_sml_raw;
  logic [22:0] fa, fb, f_big, f_sml;
  logic        a_nan, b_nan, a_inf, b_inf, eff_sub;
  logic [8:0]  e_big, e_sml, diff, lz_lim;
  logic [27:0] m_big, m_sml, m_sh, sum;
  logic        sticky, found, round_up;
  logic [4:0]  lz;
  logic [9:0]  e_norm;
  logic [26:0] norm;
  logic [24:0] mant_r;

  // Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round,
  // [0] sticky.
  always_comb begin
    sa      = data_1[31];
    ea      = data_1[30:23];
    fa      = data_1[22:0];
    sb      = data_2[31] ^ op_sel;
    eb      = data_2[30:23];
    fb      = data_2[22:0];
    a_nan   = (ea == 8'hff) && (fa != 23'd0);
    b_nan   = (eb == 8'hff) && (fb != 23'd0);
    a_inf   = (ea == 8'hff) && (fa == 23'd0);
    b_inf   = (eb == 8'hff) && (fb == 23'd0);
    eff_sub = sa ^ sb;

    if ({eb, fb} > {ea, fa}) begin
      s_big = sb; e_big_raw = eb; f_big = fb; e_sml_raw = ea; f_sml = fa;
    end else begin
      s_big = sa; e_big_raw = ea; f_big = fa; e_sml_raw = eb; f_sml = fb;
    end

    // Subnormals use an effective exponent of 1 with no hidden bit.
    e_big = (e_big_raw == 8'd0) ? 9'd1 : {1'b0, e_big_raw};
    e_sml = (e_sml_raw == 8'd0) ? 9'd1 : {1'b0, e_sml_raw};
    m_big = {1'b0, e_big_raw != 8'd0, f_big, 3'b000};
    m_sml = {1'b0, e_sml_raw != 8'd0, f_sml, 3'b000};
    diff  = e_big - e_sml;

    if (diff >= 9'd27) begin
      m_sh   = '0;
      sticky = |m_sml;
    end else begin
      m_sh   = m_sml >> diff;
      sticky = |(m_sml & ((28'd1 << diff) - 28'd1));
    end
    m_sh[0] = m_sh[0] | sticky;

    sum = eff_sub ? (m_big - m_sh) : (m_big + m_sh);

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    // Never normalise below the minimum exponent; the result becomes subnormal.
    lz_lim = e_big - 9'd1;
    if ({4'b0, lz} > lz_lim) lz = lz_lim[4:0];

    if (sum[27]) begin
      norm   = {sum[27:2], sum[1] | sum[0]};
      e_norm = {1'b0, e_big} + 10'd1;
    end else begin
      norm   = sum[26:0] << lz;
      e_norm = {1'b0, e_big} - {5'b0, lz};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'b0, round_up};
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      e_norm = e_norm + 10'd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) data_o = 32'h7fc0_0000;
    else if (a_inf)                                     data_o = {sa, 8'hff, 23'd0};
    else if (b_inf)                                     data_o = {sb, 8'hff, 23'd0};
    else if (sum == 28'd0)                              data_o = {sa & sb, 31'd0};
    else if (e_norm >= 10'd255)                         data_o = {s_big, 8'hff, 23'd0};
    else data_o = {s_big, (mant_r[23] ? e_norm[7:0] : 8'h00), mant_r[22:0]};
  end

endmodule

// File: tb/tb_fp_arith_arb.sv
// Directed self-checking bench for fp_arith_arb (NUM_REQ = 4).
module tb_fp_arith_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data_1;
  logic [127:0] req_data_2;
  logic [3:0]   req_op_sel;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;
  logic         busy;
  logic [15:0]  op_cnt;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [15:0]  exp_cnt  = 16'd0;

  fp_arith_arb #(
    .DATA_WIDTH (32),
    .NUM_REQ    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data_1 (req_data_1),
    .req_data_2 (req_data_2),
    .req_op_sel (req_op_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .op_cnt     (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with resp_ready held high: grant, CALC, RESP, completion.
  task automatic txn(input logic [3:0] valid, input logic [3:0] exp_ready,
                     input logic [31:0] exp_data, input logic [1:0] exp_id, input logic keep);
    req_valid  = valid;
    resp_ready = 1'b1;
    #1;
    check("grant", 32'(req_ready), 32'(exp_ready));
    tick();
    req_valid = keep ? valid : (valid & ~exp_ready);
    #1;
    check("calc_busy", 32'(busy), 32'd1);
    check("calc_resp_valid", 32'(resp_valid), 32'd0);
    check("calc_ready", 32'(req_ready), 32'd0);
    tick();
    #1;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_data", resp_data, exp_data);
    check("resp_id", 32'(resp_id), 32'(exp_id));
    check("resp_ready_block", 32'(req_ready), 32'd0);
    tick();
    #1;
    exp_cnt = exp_cnt + 16'd1;
    check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
    check("done_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data_1 = '0;
    req_data_2 = '0;
    req_op_sel = '0;
    resp_ready = 1'b0;
    tick();
    tick();

    // Reset state, and req_ready forced low during reset.
    req_valid = 4'b0001;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    rst       = 1'b0;
    tick();
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);

    // Single add: 1.0 + 2.0 = 3.0 from requester 0.
    req_data_1[31:0] = 32'h3f80_0000;
    req_data_2[31:0] = 32'h4000_0000;
    txn(4'b0001, 4'b0001, 32'h4040_0000, 2'd0, 1'b0);

    // Subtract with backpressure: 1.0 - 2.0 = -1.0 from requester 2 (ptr now 1).
    req_data_1[95:64] = 32'h3f80_0000;
    req_data_2[95:64] = 32'h4000_0000;
    req_op_sel        = 4'b0100;
    resp_ready        = 1'b0;
    req_valid         = 4'b0100;
    #1;
    check("sub_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1011;
    #1;
    check("sub_calc_ready", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", resp_data, 32'hbf80_0000);
      check("bp_resp_id", 32'(resp_id), 32'd2);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    #1;
    check("bp_still_valid", 32'(resp_valid), 32'd1);
    tick();
    #1;
    exp_cnt = exp_cnt + 16'd1;
    check("bp_op_cnt", 32'(op_cnt), 32'(exp_cnt));
    check("bp_idle_busy", 32'(busy), 32'd0);
    req_op_sel = '0;

    // Reset pulse so the round-robin sequence starts from ptr = 0.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = 16'd0;
    #1;
    check("rr_pre_op_cnt", 32'(op_cnt), 32'd0);

    // Round robin: all valid continuously, 2.0 + 2.0 = 4.0, grants 0,1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      req_data_1[k*32 +: 32] = 32'h4000_0000;
      req_data_2[k*32 +: 32] = 32'h4000_0000;
    end
    txn(4'b1111, 4'b0001, 32'h4080_0000, 2'd0, 1'b1);
    txn(4'b1111, 4'b0010, 32'h4080_0000, 2'd1, 1'b1);
    txn(4'b1111, 4'b0100, 32'h4080_0000, 2'd2, 1'b1);
    txn(4'b1111, 4'b1000, 32'h4080_0000, 2'd3, 1'b1);
    txn(4'b1111, 4'b0001, 32'h4080_0000, 2'd0, 1'b1);

    // Pointer skip: grant 1, then only 0 and 3 valid -> 3 first, then 0.
    txn(4'b0010, 4'b0010, 32'h4080_0000, 2'd1, 1'b0);
    txn(4'b1001, 4'b1000, 32'h4080_0000, 2'd3, 1'b0);
    txn(4'b0001, 4'b0001, 32'h4080_0000, 2'd0, 1'b0);

    // Reset mid-op: accept requester 1 (ptr would become 2), reset in CALC.
    resp_ready = 1'b1;
    req_valid  = 4'b0010;
    #1;
    check("abort_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    check("abort_calc_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = 16'd0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_cnt", 32'(op_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      tick();
      #1;
    end
    check("abort_op_cnt_hold", 32'(op_cnt), 32'd0);
    // ptr back at 0: requester 0 beats requester 2, then requester 2 is served.
    txn(4'b0101, 4'b0001, 32'h4080_0000, 2'd0, 1'b0);
    txn(4'b0100, 4'b0100, 32'h4080_0000, 2'd2, 1'b0);

    // Counter wrap: preload 0xFFFE, then two completions -> 0xFFFF -> 0x0000.
    force dut.op_cnt_q = 16'hfffe;
    #1;
    release dut.op_cnt_q;
    exp_cnt = 16'hfffe;
    txn(4'b1000, 4'b1000, 32'h4080_0000, 2'd3, 1'b0);
    txn(4'b0001, 4'b0001, 32'h4080_0000, 2'd0, 1'b0);
    check("wrap_zero", 32'(op_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
